seven_seg_scan_ctrl: RTL

- Time-multiplexed scan controller for the seven-segment display driver.
- Generates the 3-bit select for the 8:1 segment-pattern mux and the matching active-low anode enables.
- Cycles through enabled digits at a prescaled refresh rate, with an all-off dead interval between digits to suppress ghosting.
- Sits between the system clock and the mux/anode pins; has no segment datapath of its own.

---
 rtl/seven_seg_scan_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: digit select, active-low anodes, dead-time blanking.
// Optional build macro SEG_SCAN_DIM_EN adds a 4-bit brightness input for 16-level duty in SHOW.
module seven_seg_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int TICK_DIV = 100000,
  parameter int DEAD_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIGITS-1:0] digit_en,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]        brightness,
`endif
  output logic [2:0]        sel,
  output logic [DIGITS-1:0] anode,
  output logic              frame_start
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'((DEAD_CYC == 0) ? 0 : DEAD_CYC - 1);
`ifdef SEG_SCAN_DIM_EN
  localparam int SHIFT = (PW >= 4) ? PW - 4 : 0;
`endif

  typedef enum logic [1:0] {OFF, DEAD, SHOW} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     pcnt, pcnt_n;
  logic [DW-1:0]     dcnt, dcnt_n;
  logic [2:0]        sel_n, nx;
  logic [DIGITS-1:0] anode_n;
  logic              fs_n, run, tick, lit_ok;

  function automatic logic [2:0] lowest_sel(input logic [DIGITS-1:0] mask);
    logic [2:0] r;
    r = '0;
    for (int i = DIGITS - 1; i >= 0; i--)
      if (mask[i]) r = 3'(i);
    return r;
  endfunction

  // Search strictly above cur, wrapping; a lone enabled digit returns cur itself.
  function automatic logic [2:0] next_sel(input logic [2:0] cur, input logic [DIGITS-1:0] mask);
    logic [2:0] r;
    logic       found;
    int         idx;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= DIGITS; i++) begin
      idx = (int'(cur) + i) % DIGITS;
      if (!found && mask[idx]) begin
        r     = 3'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= OFF;
      sel         <= '0;
      anode       <= '1;
      frame_start <= 1'b0;
      pcnt        <= '0;
      dcnt        <= '0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      anode       <= anode_n;
      frame_start <= fs_n;
      pcnt        <= pcnt_n;
      dcnt        <= dcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    fs_n    = 1'b0;
    pcnt_n  = pcnt;
    dcnt_n  = dcnt;
    anode_n = '1;
    run     = enable && (|digit_en);
    tick    = (state != OFF) && (pcnt == PMAX);
    nx      = next_sel(sel, digit_en);

    // A dropped enable or empty mask overrides everything, including a coincident tick.
    if (!run) begin
      state_n = OFF;
      pcnt_n  = '0;
      dcnt_n  = '0;
    end else begin
      case (state)
        OFF: begin
          sel_n   = lowest_sel(digit_en);
          fs_n    = 1'b1;
          state_n = (DEAD_CYC == 0) ? SHOW : DEAD;
          pcnt_n  = '0;
          dcnt_n  = '0;
        end
        DEAD: begin
          pcnt_n = tick ? '0 : pcnt + 1'b1;
          if (dcnt == DMAX) begin
            state_n = SHOW;
            dcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + 1'b1;
          end
        end
        SHOW: begin
          pcnt_n = tick ? '0 : pcnt + 1'b1;
          if (tick) begin
            sel_n   = nx;
            fs_n    = (nx <= sel);
            state_n = (DEAD_CYC == 0) ? SHOW : DEAD;
            dcnt_n  = '0;
          end
        end
        default: state_n = OFF;
      endcase
    end

`ifdef SEG_SCAN_DIM_EN
    lit_ok = ((int'(pcnt_n) >> SHIFT) < int'(brightness));
`else
    lit_ok = 1'b1;
`endif

    // Anode is registered from next-cycle state, so mask changes show one clock later.
    if (state_n == SHOW && lit_ok)
      anode_n = ~((DIGITS'(1) << sel_n) & digit_en);
  end

endmodule
